toggle_period_monitor: RTL and testbench
========================================

Name: toggle_period_monitor

Overview:
- Downstream consumer of the divided-clock T flip-flop output (slow square wave `q`).
- Synchronises the toggle into the fast `clock_in` domain and detects its edges.
- Measures period and high time in `clock_in` cycles, counts rising edges, and flags a stuck (non-toggling) source.
- Used for on-board self-check of the divider/TFF chain and as a status source for LEDs and debug readout.

Parameters:
- CNT_W, 28: width of the period/high-time measurement counters.
- TIMEOUT, 200000000: cycles with no edge of either polarity before `stuck` asserts; must be ≤ 2^CNT_W−1.
- SYNC_STAGES, 2: flops in the input synchroniser; ≥ 2.

Ports:
- clock_in  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- toggle_in  input  1  asynchronous slow toggle (TFF `q`).
- clear  input  1  synchronous soft clear, active-high.
- rise_pulse  output  1  one-cycle pulse per detected rising edge.
- fall_pulse  output  1  one-cycle pulse per detected falling edge.
- edge_count  output  16  count of rising edges since reset/clear; wraps.
- last_period  output  CNT_W  cycles between the last two rising edges.
- high_time  output  CNT_W  cycles from the last rising edge to the following falling edge.
- period_valid  output  1  one-cycle pulse when `last_period` updates.
- stuck  output  1  level; source has not toggled for TIMEOUT cycles.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - All outputs go to 0.
  - Synchroniser flops and the previous-level register go to 0.
  - All counters go to 0 and the FSM goes to WAIT_FIRST.
  - Reset overrides everything.
- Clear (clear == 1, reset == 1):
  - Same effect as reset, except the synchroniser and previous-level register keep running.
  - An edge detected in the same cycle as clear is discarded.
- Synchroniser:
  - `sync` is the last stage of the SYNC_STAGES chain; `prev` registers `sync`.
  - A rising edge is `sync & ~prev`; a falling edge is `~sync & prev`.
- Pulse latency:
  - `rise_pulse`/`fall_pulse` are registered, high for exactly one cycle.
  - They assert SYNC_STAGES+1 edges after the first edge that samples the new `toggle_in` level.
- Counters:
  - `gap_cnt` counts cycles since the last edge of either polarity; reset to 1 on any edge.
  - `per_cnt` counts cycles since the last rising edge; `hi_cnt` is captured from `per_cnt` on a falling edge.
  - All counters saturate at 2^CNT_W−1 and never wrap.
- FSM states:
  - WAIT_FIRST (no rising edge seen yet):
    - Rising edge → MEASURE, `per_cnt` = 1, `edge_count`+1, no `period_valid`.
    - `gap_cnt` reaching TIMEOUT → STUCK.
  - MEASURE:
    - Rising edge → `last_period` = `per_cnt`, `period_valid` = 1 for one cycle, `per_cnt` = 1, `edge_count`+1.
    - Falling edge → `high_time` = `per_cnt`.
    - `gap_cnt` reaching TIMEOUT → STUCK.
  - STUCK:
    - `stuck` = 1; `last_period`/`high_time` hold.
    - Rising edge → MEASURE (as from WAIT_FIRST, no `period_valid`), `stuck` = 0 next cycle, `edge_count`+1.
    - Falling edge → WAIT_FIRST, `stuck` = 0.
- Period definition: a 50%-duty square wave of period P cycles yields `last_period` = P and `high_time` = P/2.
- Boundaries:
  - `edge_count` wraps 0xFFFF → 0x0000.
  - Rise and fall cannot be detected in the same cycle.
  - Reset or clear mid-measurement discards partial counts.
  - A saturated `per_cnt` is reported as all-ones.

Test Plan:
- Reset low for 3 cycles with `toggle_in` toggling → all outputs 0; after release, first `rise_pulse` at SYNC_STAGES+1 edges after the input change; `edge_count` = 1; no `period_valid`.
- Square wave with period 10, high 4, for 6 periods → `period_valid` pulses 5 times; `last_period` = 10; `high_time` = 4; `edge_count` = 6.
- TIMEOUT = 50, `toggle_in` held high after one rise → `stuck` asserts when `gap_cnt` reaches 50 (exactly 50 cycles after the rise pulse); next fall → `stuck` = 0, state WAIT_FIRST; next two rises → one `period_valid`.
- CNT_W = 4, period 20 → `last_period` = 15 (saturated).
- Preload `edge_count` to 0xFFFE via 65534 fast rises (period 4) → two more rises give 0x0000.
- `clear` asserted on the same cycle as a rising edge → `edge_count` = 0; no `period_valid`; the next rise starts a fresh measurement from WAIT_FIRST.

Source files
------------

// File: rtl/toggle_period_monitor.sv
// toggle_period_monitor
//   Watches the slow square wave from the divider/TFF chain. It brings the
//   toggle into the clock_in domain, detects its edges, measures the period
//   and the high time in clock_in cycles, counts rising edges, and flags a
//   source that has stopped toggling.
//
// Ports
//   clock_in     : system clock, rising edge
//   reset        : synchronous active-low reset
//   toggle_in    : asynchronous slow toggle input
//   clear        : synchronous soft clear, active-high (synchroniser keeps running)
//   rise_pulse   : one-cycle pulse per detected rising edge
//   fall_pulse   : one-cycle pulse per detected falling edge
//   edge_count   : rising edges since reset/clear, wraps
//   last_period  : cycles between the last two rising edges (saturating)
//   high_time    : cycles from a rising edge to the following falling edge
//   period_valid : one-cycle pulse when last_period updates
//   stuck        : level, no edge seen for TIMEOUT cycles
module toggle_period_monitor #(
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned TIMEOUT     = 200000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             toggle_in,
  input  logic             clear,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [15:0]      edge_count,
  output logic [CNT_W-1:0] last_period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             stuck
);

  localparam int unsigned     EC_W      = 16;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_WAIT_FIRST = 2'd0,
    S_MEASURE    = 2'd1,
    S_STUCK      = 2'd2
  } state_e;

  // Saturating increment shared by all measurement counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_c;
  logic                   rise_c;
  logic                   fall_c;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]       per_cnt_q, per_cnt_d;
  logic [EC_W-1:0]        edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]       last_period_q, last_period_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
  logic                   rise_pulse_q, rise_pulse_d;
  logic                   fall_pulse_q, fall_pulse_d;
  logic                   period_valid_q, period_valid_d;
  logic                   stuck_q, stuck_d;

  // Input synchroniser and previous-level register; only reset stops them.
  always_ff @(posedge clock_in) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_c = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_c & ~prev_q;
  assign fall_c = ~sync_c & prev_q;

  // State and measurement registers.
  always_ff @(posedge clock_in) begin
    if (!reset) begin
      state_q        <= S_WAIT_FIRST;
      gap_cnt_q      <= '0;
      per_cnt_q      <= '0;
      edge_cnt_q     <= '0;
      last_period_q  <= '0;
      high_time_q    <= '0;
      rise_pulse_q   <= 1'b0;
      fall_pulse_q   <= 1'b0;
      period_valid_q <= 1'b0;
      stuck_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      per_cnt_q      <= per_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      last_period_q  <= last_period_d;
      high_time_q    <= high_time_d;
      rise_pulse_q   <= rise_pulse_d;
      fall_pulse_q   <= fall_pulse_d;
      period_valid_q <= period_valid_d;
      stuck_q        <= stuck_d;
    end
  end

  // Next-state, counter and output logic.
  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = sat_inc(gap_cnt_q);
    per_cnt_d      = sat_inc(per_cnt_q);
    edge_cnt_d     = edge_cnt_q;
    last_period_d  = last_period_q;
    high_time_d    = high_time_q;
    rise_pulse_d   = 1'b0;
    fall_pulse_d   = 1'b0;
    period_valid_d = 1'b0;

    if (clear) begin
      // Soft clear drops any edge seen this cycle along with partial counts.
      state_d       = S_WAIT_FIRST;
      gap_cnt_d     = '0;
      per_cnt_d     = '0;
      edge_cnt_d    = '0;
      last_period_d = '0;
      high_time_d   = '0;
    end else begin
      rise_pulse_d = rise_c;
      fall_pulse_d = fall_c;

      if (rise_c || fall_c) begin
        gap_cnt_d = CNT_W'(1);
      end

      if (rise_c) begin
        per_cnt_d  = CNT_W'(1);
        edge_cnt_d = edge_cnt_q + EC_W'(1);
      end

      // Timeout is only considered on cycles without an edge.
      unique case (state_q)
        S_WAIT_FIRST: begin
          if (rise_c) begin
            state_d = S_MEASURE;
          end else if (!fall_c && (gap_cnt_q >= TIMEOUT_C)) begin
            state_d = S_STUCK;
          end
        end
        S_MEASURE: begin
          if (rise_c) begin
            last_period_d  = per_cnt_q;
            period_valid_d = 1'b1;
          end else if (fall_c) begin
            high_time_d = per_cnt_q;
          end else if (gap_cnt_q >= TIMEOUT_C) begin
            state_d = S_STUCK;
          end
        end
        S_STUCK: begin
          if (rise_c) begin
            state_d = S_MEASURE;
          end else if (fall_c) begin
            state_d = S_WAIT_FIRST;
          end
        end
        default: begin
          state_d = S_WAIT_FIRST;
        end
      endcase
    end

    stuck_d = (state_d == S_STUCK);
  end

  assign rise_pulse   = rise_pulse_q;
  assign fall_pulse   = fall_pulse_q;
  assign edge_count   = edge_cnt_q;
  assign last_period  = last_period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign stuck        = stuck_q;

endmodule

// File: tb/tb_toggle_period_monitor.sv
// Bench for toggle_period_monitor: two instances with different widths,
// timeouts and synchroniser depths share one stimulus stream and are
// compared every cycle against a time-stamp based reference model.
module tb_toggle_period_monitor;

  logic clk;
  logic rst_n;
  logic clr;
  logic tin;

  logic        ra_rp, ra_fp, ra_pv, ra_st;
  logic [15:0] ra_ec;
  logic [5:0]  ra_lp, ra_ht;
  logic        rb_rp, rb_fp, rb_pv, rb_st;
  logic [15:0] rb_ec;
  logic [3:0]  rb_lp, rb_ht;

  toggle_period_monitor #(.CNT_W(6), .TIMEOUT(50), .SYNC_STAGES(2)) dut_a (
    .clock_in(clk), .reset(rst_n), .toggle_in(tin), .clear(clr),
    .rise_pulse(ra_rp), .fall_pulse(ra_fp), .edge_count(ra_ec),
    .last_period(ra_lp), .high_time(ra_ht), .period_valid(ra_pv), .stuck(ra_st)
  );

  toggle_period_monitor #(.CNT_W(4), .TIMEOUT(15), .SYNC_STAGES(3)) dut_b (
    .clock_in(clk), .reset(rst_n), .toggle_in(tin), .clear(clr),
    .rise_pulse(rb_rp), .fall_pulse(rb_fp), .edge_count(rb_ec),
    .last_period(rb_lp), .high_time(rb_ht), .period_valid(rb_pv), .stuck(rb_st)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: counters are expressed as "cycles since an anchor".
  typedef struct {
    bit [7:0]  pipe;   // pipe[0..S-1] sampled levels, pipe[S] previous level
    longint    gap_t;  // anchor for cycles since last edge
    longint    per_t;  // anchor for cycles since last rise
    int        mode;   // 0 no rise yet, 1 measuring, 2 stuck
    bit [15:0] ec;
    longint    lp;
    longint    ht;
    bit        rp, fp, pv, st;
  } mdl_t;

  mdl_t   ma, mb;
  longint cyc;
  int     n_vec;
  int     n_err;

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input longint n, input bit rn,
                                 input bit c, input bit t, input int s,
                                 input longint cmax, input longint tmo);
    bit     sy, pr, rise, fall;
    longint gp, pp;
    sy   = m.pipe[s-1];
    pr   = m.pipe[s];
    rise = sy & !pr;
    fall = !sy & pr;
    gp   = lmin(n - 1 - m.gap_t, cmax);
    pp   = lmin(n - 1 - m.per_t, cmax);
    if (!rn) begin
      m = '{default: 0};
      m.gap_t = n;
      m.per_t = n;
      return m;
    end
    m.pipe = {m.pipe[6:0], t};
    m.rp = 1'b0; m.fp = 1'b0; m.pv = 1'b0;
    if (c) begin
      m.ec = 16'd0; m.lp = 0; m.ht = 0; m.mode = 0;
      m.gap_t = n; m.per_t = n; m.st = 1'b0;
      return m;
    end
    m.rp = rise;
    m.fp = fall;
    if (rise) begin
      m.ec = m.ec + 16'd1;
      if (m.mode == 1) begin
        m.lp = pp;
        m.pv = 1'b1;
      end
      m.mode  = 1;
      m.per_t = n - 1;
      m.gap_t = n - 1;
    end else if (fall) begin
      m.gap_t = n - 1;
      if (m.mode == 1) m.ht = pp;
      else if (m.mode == 2) m.mode = 0;
    end else if (gp >= tmo && m.mode != 2) begin
      m.mode = 2;
    end
    m.st = (m.mode == 2);
    return m;
  endfunction

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    cyc = 0;
  end

  always @(posedge clk) begin
    ma = mstep(ma, cyc, rst_n, clr, tin, 2, 63, 50);
    mb = mstep(mb, cyc, rst_n, clr, tin, 3, 15, 15);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("a_rise",   ra_rp, ma.rp);
      chk("a_fall",   ra_fp, ma.fp);
      chk("a_count",  ra_ec, ma.ec);
      chk("a_period", ra_lp, ma.lp);
      chk("a_high",   ra_ht, ma.ht);
      chk("a_pvalid", ra_pv, ma.pv);
      chk("a_stuck",  ra_st, ma.st);
      chk("b_rise",   rb_rp, mb.rp);
      chk("b_fall",   rb_fp, mb.fp);
      chk("b_count",  rb_ec, mb.ec);
      chk("b_period", rb_lp, mb.lp);
      chk("b_high",   rb_ht, mb.ht);
      chk("b_pvalid", rb_pv, mb.pv);
      chk("b_stuck",  rb_st, mb.st);
    end
  end

  int pv_dut;
  int pv_mdl;

  // Drive tin=v for k cycles (entered at a negedge), tallying period_valid of instance a.
  task automatic hold(input bit v, input int k);
    tin = v;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      pv_dut = pv_dut + int'(ra_pv);
      pv_mdl = pv_mdl + int'(ma.pv);
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    hold(tin, 1);
    clr = 1'b0;
  endtask

  int t_r, t_s;
  int r;

  initial begin
    n_vec = 0;
    n_err = 0;
    pv_dut = 0;
    pv_mdl = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    tin   = 1'b0;

    // Reset with the input toggling.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tin = ~tin;
      @(negedge clk);
      chk("rst_count", ra_ec, 0);
      chk("rst_rise", ra_rp, 0);
      chk("rst_stuck", ra_st, 0);
    end
    rst_n = 1'b1;
    hold(1'b0, 4);

    // First rise latency: SYNC_STAGES+1 edges.
    tin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_early", ra_rp, 0);
    @(negedge clk);
    chk("lat_rise", ra_rp, 1);
    chk("lat_count", ra_ec, 1);
    chk("lat_pvalid", ra_pv, 0);
    hold(1'b1, 3);

    // Square wave, period 10, high 4, six periods.
    hold(1'b0, 10);
    do_clear();
    pv_dut = 0; pv_mdl = 0;
    for (int p = 0; p < 6; p++) begin
      hold(1'b1, 4);
      hold(1'b0, 6);
    end
    hold(1'b0, 5);
    chk("sq_pv_dut", pv_dut, 5);
    chk("sq_pv_mdl", pv_mdl, 5);
    chk("sq_period", ra_lp, 10);
    chk("sq_period_mdl", ma.lp, 10);
    chk("sq_high", ra_ht, 4);
    chk("sq_count", ra_ec, 6);

    // Stuck detection after a single rise.
    do_clear();
    tin = 1'b1;
    t_r = -1; t_s = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ra_rp && t_r < 0) t_r = i;
      if (ra_st && t_s < 0) t_s = i;
    end
    chk("stuck_seen", int'(t_s >= 0), 1);
    chk("stuck_delay", t_s - t_r, 50);
    hold(1'b0, 4);
    chk("stuck_cleared", ra_st, 0);
    pv_dut = 0;
    hold(1'b1, 6); hold(1'b0, 6); hold(1'b1, 6); hold(1'b0, 6);
    chk("stuck_pv", pv_dut, 1);
    chk("stuck_period", ra_lp, 12);

    // Saturation on the 4-bit instance: period 20, high 10.
    do_clear();
    for (int p = 0; p < 3; p++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    hold(1'b0, 5);
    chk("sat_period_b", rb_lp, 15);
    chk("sat_high_b", rb_ht, 10);
    chk("sat_period_a", ra_lp, 20);

    // Randomised stimulus with occasional clear and reset.
    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        rst_n = 1'b0;
        hold(tin, int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end else if (r < 8) begin
        do_clear();
      end else begin
        hold(~tin, int'($urandom_range(1, 70)));
      end
    end

    // Clear coinciding with a detected rise.
    hold(1'b1, 4); hold(1'b0, 4); hold(1'b1, 4);
    hold(1'b0, 10);
    tin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_rise", ra_rp, 0);
    chk("clr_count", ra_ec, 0);
    chk("clr_pvalid", ra_pv, 0);
    pv_dut = 0;
    hold(1'b1, 8); hold(1'b0, 8); hold(1'b1, 6);
    chk("clr_fresh_count", ra_ec, 1);
    chk("clr_fresh_pv", pv_dut, 0);
    hold(1'b1, 2); hold(1'b0, 8); hold(1'b1, 6);
    chk("clr_next_pv", pv_dut, 1);
    chk("clr_next_period", ra_lp, 16);

    // edge_count wrap from a preloaded 0xFFFE.
    hold(1'b0, 10);
    #1;
    force dut_a.edge_cnt_q = 16'hFFFE;
    ma.ec = 16'hFFFE;
    @(negedge clk);
    release dut_a.edge_cnt_q;
    hold(1'b0, 2);
    hold(1'b1, 4);
    chk("wrap_ffff", ra_ec, 16'hFFFF);
    hold(1'b0, 4);
    hold(1'b1, 4);
    chk("wrap_zero", ra_ec, 0);
    chk("wrap_zero_mdl", ma.ec, 0);
    hold(1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
